mem_wb_latch: RTL and testbench
===============================

Name: mem_wb_latch

Overview:
- Pipeline register between the memory stage and the writeback stage of the 5-stage 32-bit CPU.
- Captures the instruction, ALU result, load data and PC each cycle, with hold (stall) and flush (bubble) support.
- Injects completed multiply/divide results into the writeback slot as a synthetic R-type write to the register named by the multdiv destination.
- Raises a stall to upstream for the injection cycle.

Parameters:
- WIDTH, 32, datapath width of the instruction, ALU, memory-data and PC fields.
- NOP_INS, 32'h00000000, instruction word placed in insOut for a bubble.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = capture upstream fields; 0 = hold current contents.
- flush  in  1  1 = load bubble at next edge.
- insIn  in  WIDTH  memory-stage instruction.
- aluIn  in  WIDTH  memory-stage ALU result / address.
- memDataIn  in  WIDTH  data read from data memory.
- pcIn  in  WIDTH  memory-stage PC+1.
- mdReady  in  1  one-cycle pulse: multdiv result valid.
- mdResult  in  WIDTH  multdiv result.
- mdDest  in  5  multdiv destination register.
- insOut  out  WIDTH  instruction presented to writeback.
- aluOut  out  WIDTH  ALU result or injected multdiv result.
- memDataOut  out  WIDTH  load data.
- pcOut  out  WIDTH  PC+1 for jal.
- valid  out  1  1 = slot holds a real or injected instruction.
- wbStall  out  1  combinational; equals pending state; upstream must freeze.
- mdOverrun  out  1  sticky error flag.

Behaviour:
- Reset (async): all outputs 0, insOut = NOP_INS, state = IDLE, held md registers 0, mdOverrun 0.
- State machine: IDLE, PENDING.
- IDLE, rising edge, priority order:
  - flush: insOut = NOP_INS; aluOut, memDataOut, pcOut = 0; valid = 0.
  - Otherwise, if enable: capture all four input fields; valid = 1.
  - Otherwise: hold all outputs.
  - Independently, if mdReady: store mdResult/mdDest, go to PENDING. A flush on the same edge does not discard the multdiv result.
- PENDING:
  - wbStall = 1 for the whole cycle.
  - Next edge, regardless of enable or flush:
    - insOut = {5'b00000, mdDest, 22'b0} (R-type, rd = mdDest).
    - aluOut = stored result; memDataOut = 0; pcOut = 0; valid = 1.
    - Return to IDLE.
  - Upstream fields are not captured on this edge. Upstream holds them because of wbStall, and they are captured on the following edge.
- Injected slot lasts exactly one cycle. Latency from mdReady to write visible on insOut/aluOut is 2 edges.
- mdReady while in PENDING: ignored (the first result wins); mdOverrun set to 1 and held until reset.
- mdDest = 0: still injected; writeback write to r0 is harmless.
- Reset asserted mid-PENDING: stored result is lost, state = IDLE, wbStall = 0 immediately (async).
- No arithmetic; all fields pass through unchanged at WIDTH bits.

Optional Feature:
- Macro MEMWB_RETIRE_COUNT_EN.
- Defined: adds output retiredCount (32 bits), reset 0.
  - Increments by 1 on every edge where the newly loaded slot has valid = 1, including injected slots.
  - Wraps from 32'hFFFFFFFF to 0.
  - Held slots (enable = 0 in IDLE) are not recounted.
- Not defined: port and counter absent; no other behaviour changes.

Test Plan:
- Reset then enable = 1, insIn = 32'h40A00004 (lw), aluIn = 8, memDataIn = 32'hDEADBEEF, pcIn = 5 -> after 1 edge insOut = 32'h40A00004, memDataOut = 32'hDEADBEEF, pcOut = 5, valid = 1.
- Captured slot, then enable = 0 for 3 edges with changed inputs -> outputs unchanged, valid = 1.
- flush = 1 with enable = 1 -> after edge insOut = 0, aluOut = 0, valid = 0; flush held with enable = 0 -> still bubble.
- mdReady pulse, mdResult = 32'h00000F00, mdDest = 7 -> next cycle wbStall = 1; following edge insOut = 32'h01C00000, aluOut = 32'h00000F00, valid = 1, wbStall = 0; next edge captures the held upstream instruction.
- mdReady on edge N and again on edge N+1 -> only the first result is injected; mdOverrun = 1 and stays 1 until reset.
- mdReady with flush on the same edge, then reset asserted between edges during PENDING -> wbStall drops immediately; no injection occurs; outputs return to reset values.

Source files
------------

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register with hold, flush and one-cycle injection of multiply/divide results.
// Optional retired-slot counter enabled by defining MEMWB_RETIRE_COUNT_EN.
module mem_wb_latch #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] NOP_INS = 32'h00000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic [WIDTH-1:0] insIn,
    input  logic [WIDTH-1:0] aluIn,
    input  logic [WIDTH-1:0] memDataIn,
    input  logic [WIDTH-1:0] pcIn,
    input  logic             mdReady,
    input  logic [WIDTH-1:0] mdResult,
    input  logic [4:0]       mdDest,
    output logic [WIDTH-1:0] insOut,
    output logic [WIDTH-1:0] aluOut,
    output logic [WIDTH-1:0] memDataOut,
    output logic [WIDTH-1:0] pcOut,
    output logic             valid,
    output logic             wbStall,
`ifdef MEMWB_RETIRE_COUNT_EN
    output logic [31:0]      retiredCount,
`endif
    output logic             mdOverrun
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] md_result_r;
    logic [4:0]       md_dest_r;

    logic [WIDTH-1:0] ins_next_s;
    logic [WIDTH-1:0] alu_next_s;
    logic [WIDTH-1:0] mem_next_s;
    logic [WIDTH-1:0] pc_next_s;
    logic             valid_next_s;
    logic             load_s;
    logic [WIDTH-1:0] inject_ins_s;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: an accepted result always spends exactly one cycle pending
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (mdReady) begin
                    next_state_s = PENDING;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PENDING: next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: upstream freezes for the whole pending cycle
    always_comb begin
        wbStall = 1'b0;
        case (state_r)
            IDLE:    wbStall = 1'b0;
            PENDING: wbStall = 1'b1;
            default: wbStall = 1'b0;
        endcase
    end

    // Synthetic R-type word with rd in bits 26:22
    always_comb begin
        inject_ins_s        = '0;
        inject_ins_s[26:22] = md_dest_r;
    end

    // Next slot contents; injection outranks flush and enable
    always_comb begin
        ins_next_s   = insOut;
        alu_next_s   = aluOut;
        mem_next_s   = memDataOut;
        pc_next_s    = pcOut;
        valid_next_s = valid;
        load_s       = 1'b0;
        if (state_r == PENDING) begin
            ins_next_s   = inject_ins_s;
            alu_next_s   = md_result_r;
            mem_next_s   = '0;
            pc_next_s    = '0;
            valid_next_s = 1'b1;
            load_s       = 1'b1;
        end else if (flush) begin
            ins_next_s   = NOP_INS;
            alu_next_s   = '0;
            mem_next_s   = '0;
            pc_next_s    = '0;
            valid_next_s = 1'b0;
            load_s       = 1'b1;
        end else if (enable) begin
            ins_next_s   = insIn;
            alu_next_s   = aluIn;
            mem_next_s   = memDataIn;
            pc_next_s    = pcIn;
            valid_next_s = 1'b1;
            load_s       = 1'b1;
        end else begin
            load_s       = 1'b0;
        end
    end

    // Slot registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            insOut     <= NOP_INS;
            aluOut     <= '0;
            memDataOut <= '0;
            pcOut      <= '0;
            valid      <= 1'b0;
        end else begin
            insOut     <= ins_next_s;
            aluOut     <= alu_next_s;
            memDataOut <= mem_next_s;
            pcOut      <= pc_next_s;
            valid      <= valid_next_s;
        end
    end

    // Held multdiv result; only accepted while idle so the first result wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_result_r <= '0;
            md_dest_r   <= 5'd0;
        end else if ((state_r == IDLE) && mdReady) begin
            md_result_r <= mdResult;
            md_dest_r   <= mdDest;
        end else begin
            md_result_r <= md_result_r;
            md_dest_r   <= md_dest_r;
        end
    end

    // Sticky overrun: a second result arrived while one was still pending
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mdOverrun <= 1'b0;
        end else if ((state_r == PENDING) && mdReady) begin
            mdOverrun <= 1'b1;
        end else begin
            mdOverrun <= mdOverrun;
        end
    end

`ifdef MEMWB_RETIRE_COUNT_EN
    // Count newly loaded valid slots; held slots are not recounted, wraps naturally
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retiredCount <= 32'd0;
        end else if (load_s && valid_next_s) begin
            retiredCount <= retiredCount + 32'd1;
        end else begin
            retiredCount <= retiredCount;
        end
    end
`else
    logic unused_load_s;
    assign unused_load_s = load_s;
`endif

endmodule

// File: tb/tb_mem_wb_latch.sv
// Scoreboard bench for mem_wb_latch: a behavioural model pushes expected slots, compared after each edge.
module tb_mem_wb_latch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] insIn = 32'd0;
    logic [31:0] aluIn = 32'd0;
    logic [31:0] memDataIn = 32'd0;
    logic [31:0] pcIn = 32'd0;
    logic        mdReady = 1'b0;
    logic [31:0] mdResult = 32'd0;
    logic [4:0]  mdDest = 5'd0;
    logic [31:0] insOut, aluOut, memDataOut, pcOut;
    logic        valid, wbStall, mdOverrun;
`ifdef MEMWB_RETIRE_COUNT_EN
    logic [31:0] retiredCount;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic        vld;
        logic        stall;
        logic        ovr;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // model state
    logic [31:0] m_ins, m_alu, m_mem, m_pc, m_cnt, m_res;
    logic        m_vld, m_pend, m_ovr;
    logic [4:0]  m_dest;

    mem_wb_latch #(.WIDTH(32), .NOP_INS(32'h00000000)) dut (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .insIn(insIn), .aluIn(aluIn), .memDataIn(memDataIn), .pcIn(pcIn),
        .mdReady(mdReady), .mdResult(mdResult), .mdDest(mdDest),
        .insOut(insOut), .aluOut(aluOut), .memDataOut(memDataOut), .pcOut(pcOut),
        .valid(valid), .wbStall(wbStall),
`ifdef MEMWB_RETIRE_COUNT_EN
        .retiredCount(retiredCount),
`endif
        .mdOverrun(mdOverrun)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ins = 32'd0; m_alu = 32'd0; m_mem = 32'd0; m_pc = 32'd0; m_vld = 1'b0;
        m_pend = 1'b0; m_ovr = 1'b0; m_res = 32'd0; m_dest = 5'd0; m_cnt = 32'd0;
    endtask

    task automatic model_edge();
        if (m_pend) begin
            m_ins = 32'(m_dest) << 22;
            m_alu = m_res; m_mem = 32'd0; m_pc = 32'd0; m_vld = 1'b1;
            m_cnt = m_cnt + 32'd1;
            m_pend = 1'b0;
            if (mdReady) m_ovr = 1'b1;
        end else begin
            if (flush) begin
                m_ins = 32'd0; m_alu = 32'd0; m_mem = 32'd0; m_pc = 32'd0; m_vld = 1'b0;
            end else if (enable) begin
                m_ins = insIn; m_alu = aluIn; m_mem = memDataIn; m_pc = pcIn; m_vld = 1'b1;
                m_cnt = m_cnt + 32'd1;
            end
            if (mdReady) begin
                m_pend = 1'b1; m_res = mdResult; m_dest = mdDest;
            end
        end
    endtask

    task automatic compare_now(input exp_t e);
        check_val("insOut", insOut, e.ins);
        check_val("aluOut", aluOut, e.alu);
        check_val("memDataOut", memDataOut, e.mem);
        check_val("pcOut", pcOut, e.pc);
        check_val("valid", {31'd0, valid}, {31'd0, e.vld});
        check_val("wbStall", {31'd0, wbStall}, {31'd0, e.stall});
        check_val("mdOverrun", {31'd0, mdOverrun}, {31'd0, e.ovr});
`ifdef MEMWB_RETIRE_COUNT_EN
        check_val("retiredCount", retiredCount, e.cnt);
`endif
    endtask

    // Inputs are already set; model the edge, clock it, compare the popped expectation
    task automatic step();
        exp_t e;
        model_edge();
        e = '{ins: m_ins, alu: m_alu, mem: m_mem, pc: m_pc, vld: m_vld,
              stall: m_pend, ovr: m_ovr, cnt: m_cnt};
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: queue empty, expected one entry");
        end else begin
            compare_now(sb_q.pop_front());
        end
    endtask

    task automatic drive(input logic en, input logic fl, input logic [31:0] ins,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        enable = en; flush = fl; insIn = ins; aluIn = alu; memDataIn = mem; pcIn = pc;
    endtask

    initial begin
        exp_t r;
        model_reset();
        r = '{ins: 32'd0, alu: 32'd0, mem: 32'd0, pc: 32'd0, vld: 1'b0,
              stall: 1'b0, ovr: 1'b0, cnt: 32'd0};
        #12;
        compare_now(r);
        @(negedge clock);
        reset = 1'b0;

        // capture a load
        drive(1'b1, 1'b0, 32'h40A00004, 32'd8, 32'hDEADBEEF, 32'd5);
        step();
        // hold for three edges with changed inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h11111111 * (i + 1), 32'd100 + i, 32'hCAFE0000 + i, 32'd50 + i);
            step();
        end
        // flush wins over enable, then bubble persists while held
        drive(1'b1, 1'b1, 32'h12345678, 32'd9, 32'd10, 32'd11);
        step();
        drive(1'b0, 1'b1, 32'h12345678, 32'd9, 32'd10, 32'd11);
        step();
        // injection: stall cycle, injected slot, then held upstream captured
        drive(1'b1, 1'b0, 32'hABCD0001, 32'd20, 32'd21, 32'd22);
        mdReady = 1'b1; mdResult = 32'h00000F00; mdDest = 5'd7;
        step();
        mdReady = 1'b0; mdResult = 32'h0; mdDest = 5'd0;
        step();
        check_val("inject_word", insOut, 32'h01C00000);
        step();
        // back-to-back results: first wins, overrun sticks
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        mdReady = 1'b1; mdResult = 32'h0000AAAA; mdDest = 5'd3;
        step();
        mdResult = 32'h0000BBBB; mdDest = 5'd4;
        step();
        mdReady = 1'b0;
        step();
        step();
        // destination r0 still injected
        mdReady = 1'b1; mdResult = 32'h00000055; mdDest = 5'd0;
        step();
        mdReady = 1'b0;
        step();
        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                  $urandom, $urandom, $urandom, $urandom);
            mdReady = 1'($urandom_range(0, 4) == 0);
            mdResult = $urandom; mdDest = 5'($urandom);
            step();
        end
        // result with flush on same edge, then async reset during pending
        mdReady = 1'b0;
        step();
        step();
        drive(1'b1, 1'b1, 32'h77777777, 32'd1, 32'd2, 32'd3);
        mdReady = 1'b1; mdResult = 32'h00001234; mdDest = 5'd9;
        step();
        mdReady = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        compare_now(r);
        @(negedge clock);
        reset = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
